// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake bundle for pipe_stage_buf: upstream offer side plus downstream head side.
// slave is the buffer's view; master is the view of whatever drives it and consumes its output.
interface pipe_stage_buf_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 2
) ();
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with one skid entry, valid/ready handshake and synchronous flush.
// Define PIPE_STAGE_BUF_PERF_EN to enable the saturating downstream stall counter.
module pipe_stage_buf #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    pipe_stage_buf_if.slave      bus,
    output logic [31:0]          stall_cycles
);
    localparam int unsigned DW = LANES * WIDTH;

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   main_q, main_d;
    logic [DW-1:0]   skid_q, skid_d;
    logic            in_ready_w;
    logic            out_valid_w;
    logic            accept;
    logic            emit;

    // in_ready comes from registered state only, so out_ready never reaches upstream combinationally.
    always_comb begin
        in_ready_w    = (state_q != StFull);
        out_valid_w   = (state_q != StEmpty) && !flush;
        bus.in_ready  = in_ready_w;
        bus.out_valid = out_valid_w;
        bus.out_data  = main_q;
    end

    assign accept = bus.in_valid && in_ready_w && !flush;
    assign emit   = out_valid_w && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d = StOne;
                        main_d  = bus.in_data;
                    end
                end
                StOne: begin
                    if (accept && emit) begin
                        main_d = bus.in_data;
                    end else if (accept) begin
                        state_d = StFull;
                        skid_d  = bus.in_data;
                    end else if (emit) begin
                        state_d = StEmpty;
                        main_d  = '0;
                    end
                end
                StFull: begin
                    if (emit) begin
                        state_d = StOne;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_BUF_PERF_EN
    logic [31:0] stall_q;

    // Counts edges where a live head is refused downstream; flush does not clear it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (out_valid_w && !bus.out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed, table-driven bench for pipe_stage_buf plus hand-written reset, flush and counter sequences.
module tb_pipe_stage_buf;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned LANES = 2;
    localparam int unsigned DW    = WIDTH * LANES;
`ifdef PIPE_STAGE_BUF_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [DW-1:0] P0 = {32'h0000_3000, 32'h2408_0001};
    localparam logic [DW-1:0] P1 = {32'h0000_3004, 32'h2409_0002};
    localparam logic [DW-1:0] DA = {32'h0000_1000, 32'hAAAA_0001};
    localparam logic [DW-1:0] DB = {32'h0000_1004, 32'hBBBB_0002};
    localparam logic [DW-1:0] DC = {32'h0000_1008, 32'hCCCC_0003};
    localparam logic [DW-1:0] DX = {32'hDEAD_BEEF, 32'h5555_0009};
    localparam logic [DW-1:0] Z  = '0;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] stall_cycles;

    pipe_stage_buf_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

    pipe_stage_buf #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .bus          (bus),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int unsigned exp_stall = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ov, input logic ir, input logic [DW-1:0] od,
                              input logic [31:0] st);
        check({tag, ".out_valid"}, DW'(bus.out_valid), DW'(ov));
        check({tag, ".in_ready"}, DW'(bus.in_ready), DW'(ir));
        check({tag, ".out_data"}, bus.out_data, od);
        check({tag, ".stall"}, DW'(stall_cycles), DW'(st));
    endtask

    typedef struct {
        logic          fl;
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          ov;
        logic          ir;
        logic [DW-1:0] od;
    } vec_t;

    function automatic vec_t mk(input logic fl, input logic iv, input logic [DW-1:0] d,
                                input logic ordy, input logic ov, input logic ir,
                                input logic [DW-1:0] od);
        vec_t v;
        v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy; v.ov = ov; v.ir = ir; v.od = od;
        return v;
    endfunction

    vec_t vecs[23];

    initial begin
        // Expected outputs are the pre-edge view with this row's inputs applied.
        vecs[0]  = mk(0, 1, P0, 1, 0, 1, Z);   // pass-through
        vecs[1]  = mk(0, 1, P1, 1, 1, 1, P0);
        vecs[2]  = mk(0, 0, Z,  1, 1, 1, P1);
        vecs[3]  = mk(0, 0, Z,  1, 0, 1, Z);
        vecs[4]  = mk(0, 1, DA, 0, 0, 1, Z);   // skid fill
        vecs[5]  = mk(0, 1, DB, 0, 1, 1, DA);
        vecs[6]  = mk(0, 1, DX, 0, 1, 0, DA);  // back-pressure while full
        vecs[7]  = mk(0, 1, DX, 0, 1, 0, DA);
        vecs[8]  = mk(0, 1, DX, 0, 1, 0, DA);
        vecs[9]  = mk(0, 1, DX, 0, 1, 0, DA);
        vecs[10] = mk(0, 0, Z,  1, 1, 0, DA);
        vecs[11] = mk(0, 0, Z,  1, 1, 1, DB);
        vecs[12] = mk(0, 0, Z,  0, 0, 1, Z);
        vecs[13] = mk(0, 1, DA, 0, 0, 1, Z);   // flush while full
        vecs[14] = mk(0, 1, DB, 0, 1, 1, DA);
        vecs[15] = mk(1, 1, DC, 1, 0, 0, DA);
        vecs[16] = mk(0, 0, Z,  1, 0, 1, Z);
        vecs[17] = mk(0, 0, Z,  1, 0, 1, Z);
        vecs[18] = mk(0, 1, DA, 0, 0, 1, Z);   // flush drops an offer in ONE
        vecs[19] = mk(1, 1, DB, 1, 0, 1, DA);
        vecs[20] = mk(0, 0, Z,  1, 0, 1, Z);
        vecs[21] = mk(1, 1, DC, 1, 0, 1, Z);   // flush while empty
        vecs[22] = mk(0, 0, Z,  1, 0, 1, Z);

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #2;
        check_outs("reset", 1'b0, 1'b1, Z, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            flush         = vecs[i].fl;
            bus.in_valid  = vecs[i].iv;
            bus.in_data   = vecs[i].d;
            bus.out_ready = vecs[i].ordy;
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].ov, vecs[i].ir, vecs[i].od, exp_stall);
            @(posedge clk);
            if (PERF && vecs[i].ov && !vecs[i].ordy) exp_stall++;
            @(negedge clk);
        end
        flush = 1'b0;

        // Stall counter: 5 refused edges, survives flush, cleared by reset.
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        reset = 1'b1;
        #2;
        check("perf.reset", DW'(stall_cycles), Z);
        reset = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = DA;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_outs("perf.hold5", 1'b1, 1'b1, DA, PERF ? 32'd5 : 32'd0);
        flush = 1'b1;
        #1;
        check("perf.flush_ov", DW'(bus.out_valid), Z);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check_outs("perf.after_flush", 1'b0, 1'b1, Z, PERF ? 32'd5 : 32'd0);

        // Fill to FULL, then assert reset between edges with handshake inputs active.
        bus.in_valid = 1'b1; bus.in_data = DA;
        @(posedge clk);
        @(negedge clk);
        bus.in_data = DB;
        @(posedge clk);
        @(negedge clk);
        check_outs("full", 1'b1, 1'b0, DA, PERF ? 32'd6 : 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check_outs("async_reset", 1'b0, 1'b1, Z, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_outs($sformatf("idle%0d", k), 1'b0, 1'b1, Z, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
